// File: rtl/hazard_controller.sv
// hazard_controller: RV32I five-stage stall/flush/forward control with data-memory wait FSM.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit FWD_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        MemReadE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemFault,
  output logic [15:0] StallCount
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_stall_cnt;
  logic          w_lu, w_mw, w_hold, w_br, w_ld, w_fwd_ok;
  assign w_lu = MemReadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  assign w_mw = MemReqM && !MemReadyM;
  // a wait already in progress is held by MemReadyM alone
  assign w_hold = !rst && (r_state == FAULT || (r_state == MEM_WAIT ? !MemReadyM : w_mw));
  assign w_br = !rst && !w_hold && PCSrcE;
  assign w_ld = !rst && !w_hold && !PCSrcE && w_lu;
  assign w_fwd_ok = FWD_EN && !rst && r_state != FAULT;
  assign StallF = w_hold || w_ld;
  assign StallD = w_hold || w_ld;
  assign StallE = w_hold;
  assign StallM = w_hold;
  assign FlushW = w_hold;
  assign FlushD = w_br;
  assign FlushE = w_br || w_ld;
  assign ForwardAE = !w_fwd_ok ? 2'b00 :
                     (RegWriteM && RdM != '0 && RdM == Rs1E) ? 2'b10 :
                     (RegWriteW && RdW != '0 && RdW == Rs1E) ? 2'b01 : 2'b00;
  assign ForwardBE = !w_fwd_ok ? 2'b00 :
                     (RegWriteM && RdM != '0 && RdM == Rs2E) ? 2'b10 :
                     (RegWriteW && RdW != '0 && RdW == Rs2E) ? 2'b01 : 2'b00;
  assign MemFault = r_state == FAULT;
  assign StallCount = r_stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (StallF && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      case (r_state)
        RUN: if (w_mw) begin
          r_state <= MEM_WAIT;
          r_cnt   <= CW'(1);
        end
        MEM_WAIT: if (MemReadyM) r_state <= RUN;
        else begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(MEM_TIMEOUT - 1)) r_state <= FAULT;
        end
        default: r_state <= FAULT;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: random + directed checks of three hazard_controller configurations against a reference model.
module tb_hazard_controller;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [2:0] sf, sd, se, sm, fd, fe, fw, mf;
  logic [1:0] fa [3];
  logic [1:0] fb [3];
  logic [15:0] sc [3];
  int n_chk = 0;
  int n_fail = 0;
  bit m_wait [3];
  bit m_fault [3];
  int m_n [3];
  int m_sc [3];

  always #5 clk = ~clk;

  // instance 0: defaults, 1: forwarding disabled, 2: short timeout
  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_controller #(.MEM_TIMEOUT(g == 2 ? 4 : 15), .FWD_EN(g != 1)) u_dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .StallF(sf[g]), .StallD(sd[g]), .StallE(se[g]), .StallM(sm[g]),
      .FlushD(fd[g]), .FlushE(fe[g]), .FlushW(fw[g]),
      .ForwardAE(fa[g]), .ForwardBE(fb[g]),
      .MemFault(mf[g]), .StallCount(sc[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int timeout_of(int k);
    return k == 2 ? 4 : 15;
  endfunction

  function automatic logic [1:0] fwd_sel(int k, logic [4:0] rs);
    if (k == 1 || m_fault[k]) return 2'b00;
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,MemFault}
  function automatic logic [11:0] model_out(int k);
    logic s_f, s_d, s_e, s_m, f_d, f_e, f_w, frozen, lu;
    if (rst) return '0;
    {s_f, s_d, s_e, s_m, f_d, f_e, f_w} = '0;
    lu = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (m_fault[k]) frozen = 1'b1;
    else if (m_wait[k]) frozen = !MemReadyM;
    else frozen = MemReqM && !MemReadyM;
    if (frozen) {s_f, s_d, s_e, s_m, f_w} = '1;
    else if (PCSrcE) {f_d, f_e} = '1;
    else if (lu) {s_f, s_d, f_e} = '1;
    return {s_f, s_d, s_e, s_m, f_d, f_e, f_w, fwd_sel(k, Rs1E), fwd_sel(k, Rs2E), m_fault[k]};
  endfunction

  function automatic logic [11:0] dut_out(int k);
    return {sf[k], sd[k], se[k], sm[k], fd[k], fe[k], fw[k], fa[k], fb[k], mf[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_wait[k] = 0; m_fault[k] = 0; m_n[k] = 0; m_sc[k] = 0;
    end
  endtask

  // m_n holds the access-cycle number of the upcoming cycle while a wait is open
  task automatic model_step(int k);
    logic [11:0] o;
    if (rst) begin
      m_wait[k] = 0; m_fault[k] = 0; m_n[k] = 0; m_sc[k] = 0;
      return;
    end
    o = model_out(k);
    if (o[11] && m_sc[k] < 65535) m_sc[k]++;
    if (m_fault[k]) return;
    if (m_wait[k]) begin
      if (MemReadyM) m_wait[k] = 0;
      else if (m_n[k] == timeout_of(k)) begin m_fault[k] = 1; m_wait[k] = 0; end
      else m_n[k]++;
    end else if (MemReqM && !MemReadyM) begin
      m_wait[k] = 1; m_n[k] = 2;
    end
  endtask

  task automatic observe();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out%0d", k), 32'(dut_out(k)), 32'(model_out(k)));
      check($sformatf("cnt%0d", k), 32'(sc[k]), 32'(m_sc[k]));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic clr_in();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM} = '0;
    MemReadyM = 1'b1;
  endtask

  initial begin
    model_reset();
    clr_in();
    rst = 1'b1;
    PCSrcE = 1; MemReqM = 1; MemReadyM = 0; MemReadE = 1; RdE = 5; Rs1D = 5;
    RegWriteM = 1; RdM = 3; Rs1E = 3;
    #2;
    for (int k = 0; k < 3; k++) begin
      check("rst_out", 32'(dut_out(k)), 0);
      check("rst_cnt", 32'(sc[k]), 0);
    end
    @(posedge clk); #1;
    clr_in();
    rst = 1'b0;
    // load-use: one stall cycle
    MemReadE = 1; RdE = 5; Rs2D = 5;
    observe();
    check("lu_out", 32'(dut_out(0)), 32'h0C40);
    advance();
    clr_in();
    observe();
    check("lu_cnt", 32'(sc[0]), 1);
    check("lu_end", 32'(sf[0]), 0);
    advance();
    MemReadE = 1; RdE = 0; Rs1D = 0;
    observe();
    check("x0_stall", 32'(sf[0]), 0);
    advance();
    clr_in();
    RdM = 3; RdW = 3; RegWriteM = 1; RegWriteW = 1; Rs1E = 3;
    observe();
    check("fwd_m", 32'(fa[0]), 2);
    check("fwd_off", 32'(fa[1]), 0);
    RegWriteM = 0;
    #1;
    check("fwd_w", 32'(fa[0]), 1);
    advance();
    clr_in();
    PCSrcE = 1;
    observe();
    check("br", 32'(dut_out(0)), 32'h00C0);
    advance();
    clr_in();
    rst = 1'b1;
    #1 model_reset();
    advance();
    rst = 1'b0;
    // memory wait with a pending branch
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int c = 1; c <= 3; c++) begin
      observe();
      check("mwb_stall", 32'(dut_out(0)), 32'h0F20);
      advance();
    end
    MemReadyM = 1;
    observe();
    check("mwb_rel", 32'(dut_out(0)), 32'h00C0);
    advance();
    clr_in();
    observe();
    check("mwb_cnt", 32'(sc[0]), 3);
    check("mwb_nofault", 32'(mf[2]), 0);
    advance();
    // timeout on the MEM_TIMEOUT=4 instance
    MemReqM = 1; MemReadyM = 0;
    for (int c = 1; c <= 4; c++) begin
      observe();
      check("to_pre", 32'(mf[2]), 0);
      advance();
    end
    observe();
    check("to_fault", 32'(dut_out(2)), 32'h0F21);
    check("to_long", 32'(mf[0]), 0);
    advance();
    for (int c = 0; c < 65600; c++) begin
      observe();
      advance();
    end
    observe();
    check("sat", 32'(sc[2]), 32'hFFFF);
    check("sat_fault", 32'(mf[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("arst_out", 32'(dut_out(k)), 0);
      check("arst_cnt", 32'(sc[k]), 0);
    end
    model_reset();
    advance();
    rst = 1'b0;
    clr_in();
    for (int c = 0; c < 3000; c++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3));
      RdW = 5'($urandom_range(0, 3));
      MemReadE = 1'($urandom % 2); RegWriteM = 1'($urandom % 2);
      RegWriteW = 1'($urandom % 2); PCSrcE = ($urandom % 6) == 0;
      MemReqM = ($urandom % 3) == 0; MemReadyM = ($urandom % 3) != 0;
      rst = ($urandom % 150) == 0;
      if (rst) model_reset();
      observe();
      advance();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing block for the five-stage RV32I core. It compares register fields across D/E/M/W and drives per-stage stall/flush enables and EX-stage forwarding selects. It also runs a small state machine that freezes the pipeline while the data memory inserts wait states. It sits beside the pipeline registers and consumes the control bits the decoder produces (`MemReadD`, `RegWriteD`, `JumpD`, `BranchD`, after they are registered down the pipe).

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum consecutive data-memory wait cycles before fault. Legal range 2..255.
- `FWD_EN`, default 1: 1 enables forwarding; 0 forces `ForwardAE`/`ForwardBE` to 00.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `Rs1D`, `Rs2D`, in, 5: source registers of the instruction in Decode.
- `Rs1E`, `Rs2E`, `RdE`, in, 5: source and destination registers in Execute.
- `RdM`, `RdW`, in, 5: destination registers in Memory and Writeback.
- `MemReadE`, in, 1: Execute instruction is a load.
- `RegWriteM`, `RegWriteW`, in, 1: register-write enables of the M and W instructions.
- `PCSrcE`, in, 1: taken branch, jal or jalr resolved in Execute.
- `MemReqM`, in, 1: M instruction accesses data memory (load or store).
- `MemReadyM`, in, 1: data memory completes the M access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM`, out, 1: hold the PC and the D/E/M pipeline registers.
- `FlushD`, `FlushE`, `FlushW`, out, 1: load a bubble (all control bits zero) into that pipeline register.
- `ForwardAE`, `ForwardBE`, out, 2: ALU operand select. 00 = register file, 10 = M-stage ALU result, 01 = W-stage result.
- `MemFault`, out, 1: sticky memory-timeout fault.
- `StallCount`, out, 16: saturating count of cycles with `StallF` = 1.

## Operation
States are RUN, MEM_WAIT and FAULT. All stall, flush and forward outputs are combinational from the state and the current inputs. While `rst` = 1, every output is 0.

- **Load-use hazard (`lu`):** `MemReadE` and `RdE` != 0 and (`RdE` == `Rs1D` or `RdE` == `Rs2D`).
- **Memory wait (`mw`):** `MemReqM` and not `MemReadyM`.

RUN, with priority `mw` > `PCSrcE` > `lu`:
- `mw`:
  - `StallF`, `StallD`, `StallE`, `StallM` = 1 and `FlushW` = 1.
  - `FlushD` = `FlushE` = 0. A pending `PCSrcE` is held in E and takes effect once the wait ends.
  - Next state is MEM_WAIT; the wait counter is loaded with 1.
- else `PCSrcE`: `FlushD` = `FlushE` = 1 and no stall. The decoder guarantees `lu` and `PCSrcE` never occur together; if they do, the branch wins.
- else `lu`: `StallF` = `StallD` = 1 and `FlushE` = 1. The bubble clears the match on the next cycle, so the stall lasts exactly one cycle.

MEM_WAIT:
- `MemReadyM` = 1: all stalls and `FlushW` drop in that same cycle, and the RUN rules above apply combinationally to that cycle. Next state is RUN.
- `MemReadyM` = 0: the same stall pattern as the RUN `mw` case. The counter increments.
  - If this is wait cycle `MEM_TIMEOUT`, next state is FAULT.

FAULT:
- Stall outputs and `FlushW` are held at 1. Flushes D/E are 0 and forwards are 00.
- `MemFault` = 1, leaving only via `rst`.

Forwarding, per operand X ∈ {1, 2}, with the M-stage source taking priority:
- 10 if `RegWriteM` and `RdM` != 0 and `RdM` == `RsXE`.
- else 01 if `RegWriteW` and `RdW` != 0 and `RdW` == `RsXE`.
- else 00.

`StallCount` increments on every clock where `StallF` = 1 and saturates at 16'hFFFF.

## Timing
Reset (async): state = RUN, wait counter = 0, `MemFault` = 0, `StallCount` = 0. All outputs are 0 while `rst` is held.
- Reset mid-MEM_WAIT or mid-FAULT aborts immediately.

Hazard latency:
- Load-use costs exactly 1 stall cycle.
- Taken branch or jump costs 2 flushed slots and 0 stall cycles.

Memory wait:
- Number access cycles from 1, where cycle 1 is the first cycle with `mw` in RUN. Stalls are asserted in cycle 1 itself.
- `MemReadyM` high in any cycle n ≤ `MEM_TIMEOUT` ends the wait in cycle n, so the access costs n − 1 stall cycles.
- No ready through cycle `MEM_TIMEOUT` means `MemFault` = 1 from cycle `MEM_TIMEOUT` + 1.
- Back-to-back accesses are allowed: a new `mw` in the cycle after completion re-enters MEM_WAIT with the counter at 1.

Counter width is ceil(log2(`MEM_TIMEOUT` + 1)) bits.

## Test plan
- **Load-use:** `MemReadE` = 1, `RdE` = 5, `Rs2D` = 5 for one cycle. Required: `StallF` = `StallD` = `FlushE` = 1 for exactly 1 cycle; `StallCount` goes 0→1.
- **x0 and forwarding:**
  - `RdE` = 0 with `Rs1D` = 0 and `MemReadE` = 1: no stall.
  - `RdM` = 3, `RdW` = 3, both write enables set, `Rs1E` = 3: `ForwardAE` = 10.
  - Clear `RegWriteM`: `ForwardAE` = 01.
  - `FWD_EN` = 0: `ForwardAE` = 00.
- **Branch:** `PCSrcE` = 1 with no `mw`. Required: `FlushD` = `FlushE` = 1 in the same cycle and all stalls 0.
- **Memory wait plus branch:** `MemReqM` = 1, `MemReadyM` low for 3 cycles then high, with `PCSrcE` = 1 throughout. Required: stalls and `FlushW` high for cycles 1–3 with `FlushD`/`FlushE` = 0; in cycle 4 stalls drop and `FlushD` = `FlushE` = 1; `StallCount` = 3.
- **Timeout:** `MEM_TIMEOUT` = 4 with `MemReadyM` held low. Required: `MemFault` = 1 from cycle 5 and stalls stuck high.
  - Then pulse `rst` asynchronously mid-cycle: all outputs 0 immediately, `MemFault` = 0, `StallCount` = 0.
- **Saturation:** force `mw` with a large `MEM_TIMEOUT` (or repeated waits) for more than 65535 stall cycles. Required: `StallCount` holds at 16'hFFFF.
